// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue unit and its register file.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 3;
  localparam int NREG   = 8;
  localparam int REG_AW = $clog2(NREG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic              cin;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic              imm_sel;
    logic [DATA_W-1:0] imm;
  } alu_req_t;

endpackage

// File: rtl/alu_regfile.sv
// Purpose: NREG x DATA_W register file, two operand read ports, one debug read, one write.
// Latency: reads combinational; write visible the cycle after the write edge.
// Backpressure: none; always accepts a write when i_we is high.
// Ports: clk/rst (async active-high clear), i_ra_addr/o_ra_data, i_rb_addr/o_rb_data,
//        i_dbg_addr/o_dbg_data, i_we/i_wa/i_wd write port.
module alu_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] i_ra_addr,
  output logic [DATA_W-1:0] o_ra_data,
  input  logic [REG_AW-1:0] i_rb_addr,
  output logic [DATA_W-1:0] o_rb_data,
  input  logic [REG_AW-1:0] i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_wa,
  input  logic [DATA_W-1:0] i_wd
);

  logic [DATA_W-1:0] r_mem [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_ra_data  = r_mem[i_ra_addr];
  assign o_rb_data  = r_mem[i_rb_addr];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// Purpose: issues one request at a time to an external combinational ALU, writes W back, returns a response.
// Latency: handshake seen in cycle N -> rsp_valid in cycle N+2; at most one op every 3 cycles.
// Backpressure: req_ready only in IDLE; response held in RESP until rsp_ready.
// Ports: req_* request channel (valid/ready), alu_* drive/capture of the external ALU,
//        rsp_* response channel (valid/ready), dbg_addr/dbg_data combinational regfile peek.
module alu_issue_unit
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic              req_cin,
  input  logic [REG_AW-1:0] req_rd,
  input  logic [REG_AW-1:0] req_ra,
  input  logic [REG_AW-1:0] req_rb,
  input  logic              req_imm_sel,
  input  logic [DATA_W-1:0] req_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_c,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic [DATA_W-1:0] alu_w,
  input  logic              alu_zero,
  input  logic              alu_negative,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_negative,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  alu_req_t          w_req;
  logic [DATA_W-1:0] w_ra_data;
  logic [DATA_W-1:0] w_rb_data;
  logic              w_we;

  state_e            r_state;
  logic [REG_AW-1:0] r_rd;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic              r_alu_c;
  logic [OP_W-1:0]   r_alu_opcode;
  logic [DATA_W-1:0] r_rsp_result;
  logic              r_rsp_zero;
  logic              r_rsp_negative;

  assign w_req = '{op: req_op, cin: req_cin, rd: req_rd, ra: req_ra, rb: req_rb,
                   imm_sel: req_imm_sel, imm: req_imm};

  // Writeback coincides with the response capture edge, so a following request
  // accepted from IDLE always reads the updated value.
  assign w_we = (r_state == EXEC);

  alu_regfile u_regfile (
    .clk        (clk),
    .rst        (rst),
    .i_ra_addr  (w_req.ra),
    .o_ra_data  (w_ra_data),
    .i_rb_addr  (w_req.rb),
    .o_rb_data  (w_rb_data),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data),
    .i_we       (w_we),
    .i_wa       (r_rd),
    .i_wd       (alu_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_rd           <= '0;
      r_req_ready    <= 1'b1;
      r_rsp_valid    <= 1'b0;
      r_alu_a        <= '0;
      r_alu_b        <= '0;
      r_alu_c        <= 1'b0;
      r_alu_opcode   <= '0;
      r_rsp_result   <= '0;
      r_rsp_zero     <= 1'b0;
      r_rsp_negative <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            // Operands are sampled here, before any writeback, so rd==ra/rb is safe.
            r_alu_a      <= w_ra_data;
            r_alu_b      <= w_req.imm_sel ? w_req.imm : w_rb_data;
            r_alu_c      <= w_req.cin;
            r_alu_opcode <= w_req.op;
            r_rd         <= w_req.rd;
            r_req_ready  <= 1'b0;
            r_state      <= EXEC;
          end
        end
        EXEC: begin
          r_rsp_result   <= alu_w;
          r_rsp_zero     <= alu_zero;
          r_rsp_negative <= alu_negative;
          r_rsp_valid    <= 1'b1;
          r_state        <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready    = r_req_ready;
  assign rsp_valid    = r_rsp_valid;
  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign alu_c        = r_alu_c;
  assign alu_opcode   = r_alu_opcode;
  assign rsp_result   = r_rsp_result;
  assign rsp_zero     = r_rsp_zero;
  assign rsp_negative = r_rsp_negative;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Purpose: self-checking bench for alu_issue_unit with an adder stub ALU and a response scoreboard.
// Latency: n/a.
// Backpressure: exercises stalled responses and a request held across RESP.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic        req_cin = 1'b0;
  logic [2:0]  req_rd = '0, req_ra = '0, req_rb = '0;
  logic        req_imm_sel = 1'b0;
  logic [15:0] req_imm = '0;
  logic [15:0] alu_a, alu_b, alu_w;
  logic        alu_c, alu_zero, alu_negative;
  logic [2:0]  alu_opcode;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic        rsp_zero, rsp_negative;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  always #5 clk = ~clk;

  // Stub ALU: W = A + B + C.
  assign alu_w        = alu_a + alu_b + {15'd0, alu_c};
  assign alu_zero     = (alu_w == 16'd0);
  assign alu_negative = alu_w[15];

  alu_issue_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_cin(req_cin),
    .req_rd(req_rd), .req_ra(req_ra), .req_rb(req_rb), .req_imm_sel(req_imm_sel), .req_imm(req_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_opcode(alu_opcode),
    .alu_w(alu_w), .alu_zero(alu_zero), .alu_negative(alu_negative),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_negative(rsp_negative),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  typedef struct packed {
    logic [15:0] res;
    logic        z;
    logic        n;
    logic [2:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] mreg [8];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mreg[i] = 16'd0;
  endtask

  // Present a request at a negedge (held until the task that accepts it drops it).
  task automatic drive_req(input logic [2:0] op, input logic cin, input logic [2:0] rd,
                           input logic [2:0] ra, input logic [2:0] rb, input logic imm_sel,
                           input logic [15:0] imm);
    req_op = op; req_cin = cin; req_rd = rd; req_ra = ra; req_rb = rb;
    req_imm_sel = imm_sel; req_imm = imm; req_valid = 1'b1;
  endtask

  // Expected result from the bench's own regfile model and the stub ALU definition.
  task automatic sb_push();
    exp_t e;
    e.a   = mreg[req_ra];
    e.b   = req_imm_sel ? req_imm : mreg[req_rb];
    e.res = e.a + e.b + {15'd0, req_cin};
    e.z   = (e.res == 16'd0);
    e.n   = e.res[15];
    e.rd  = req_rd;
    e.op  = req_op;
    sb_q.push_back(e);
    mreg[req_rd] = e.res;
  endtask

  task automatic wait_accept();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("accept_timeout", n, 0);
  endtask

  // Request driven at a negedge; returns just after the accepting posedge.
  task automatic issue(input logic [2:0] op, input logic cin, input logic [2:0] rd,
                       input logic [2:0] ra, input logic [2:0] rb, input logic imm_sel,
                       input logic [15:0] imm);
    @(negedge clk);
    drive_req(op, cin, rd, ra, rb, imm_sel, imm);
    wait_accept();
    sb_push();
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic pop_and_handshake();
    exp_t e;
    check("sb_size", sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("rsp_result", rsp_result, e.res);
      check("rsp_zero", rsp_zero, e.z);
      check("rsp_negative", rsp_negative, e.n);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      dbg_addr = e.rd;
      #1;
      check("post_rsp_valid", rsp_valid, 0);
      check("post_req_ready", req_ready, 1);
      check("post_rsp_held", rsp_result, e.res);
      check("writeback", dbg_data, e.res);
    end
  endtask

  // EXEC at the first negedge after accept, RESP at the second.
  task automatic check_latency();
    @(negedge clk);
    check("exec_rsp_valid", rsp_valid, 0);
    check("exec_req_ready", req_ready, 0);
    if (sb_q.size() > 0) begin
      check("alu_a", alu_a, sb_q[0].a);
      check("alu_b", alu_b, sb_q[0].b);
      check("alu_opcode", alu_opcode, sb_q[0].op);
    end
    @(negedge clk);
    check("resp_rsp_valid", rsp_valid, 1);
  endtask

  task automatic complete(input int stall);
    logic [15:0] snap_r;
    logic        snap_z, snap_n;
    check_latency();
    snap_r = rsp_result; snap_z = rsp_zero; snap_n = rsp_negative;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", rsp_valid, 1);
      check("stall_req_ready", req_ready, 0);
      check("stall_result", rsp_result, snap_r);
      check("stall_flags", {rsp_zero, rsp_negative}, {snap_z, snap_n});
    end
    pop_and_handshake();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    logic [15:0] a_first;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_req_ready", req_ready, 1);
    check("reset_alu_a", alu_a, 0);

    // Immediate load into r1 from r0.
    issue(3'd0, 1'b0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h1234);
    complete(0);
    dbg_addr = 3'd1; #1;
    check("imm_load_r1", dbg_data, 16'h1234);

    // Zero flag: r3 = 0xFFFF + 1.
    issue(3'd1, 1'b0, 3'd1, 3'd0, 3'd0, 1'b1, 16'hFFFF); complete(0);
    issue(3'd2, 1'b0, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0001); complete(0);
    issue(3'd3, 1'b0, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000); complete(0);
    check("zero_result", rsp_result, 16'h0000);
    check("zero_flag", rsp_zero, 1);

    // Negative flag via carry-in: r5 = 0x7FFF + 0 + 1.
    issue(3'd4, 1'b0, 3'd4, 3'd0, 3'd0, 1'b1, 16'h7FFF); complete(0);
    issue(3'd5, 1'b1, 3'd5, 3'd4, 3'd0, 1'b1, 16'h0000); complete(0);
    check("neg_result", rsp_result, 16'h8000);
    check("neg_flag", rsp_negative, 1);

    // Backpressure with a second request held during the stalled response.
    issue(3'd6, 1'b0, 3'd6, 3'd5, 3'd2, 1'b0, 16'h0000);
    a_first = mreg[5];
    check_latency();
    drive_req(3'd7, 1'b0, 3'd7, 3'd6, 3'd0, 1'b1, 16'h0001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("held_req_ready", req_ready, 0);
      check("held_rsp_valid", rsp_valid, 1);
      check("held_alu_a", alu_a, a_first);
      check("held_result", rsp_result, 16'h8001);
    end
    pop_and_handshake();
    check("held_not_yet", alu_a, a_first);
    sb_push();
    @(posedge clk);
    #1 req_valid = 1'b0;
    complete(0);
    check("held_second_r7", rsp_result, 16'h8002);

    // rd == ra accumulation.
    issue(3'd0, 1'b0, 3'd1, 3'd0, 3'd0, 1'b1, 16'd5); complete(0);
    issue(3'd0, 1'b0, 3'd1, 3'd1, 3'd0, 1'b1, 16'd3); complete(1);
    check("acc_first", rsp_result, 16'd8);
    issue(3'd0, 1'b0, 3'd1, 3'd1, 3'd0, 1'b1, 16'd3); complete(0);
    check("acc_second", rsp_result, 16'd11);

    // Abort in EXEC: no writeback, no response.
    issue(3'd2, 1'b0, 3'd7, 3'd1, 3'd0, 1'b1, 16'h0100);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    void'(sb_q.pop_front());
    model_clear();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_rsp", rsp_valid, 0);
    end
    dbg_addr = 3'd7; #1;
    check("abort_no_wb", dbg_data, 16'h0000);
    check("abort_req_ready", req_ready, 1);

    // Mid-sim reset clears everything after writing a few registers.
    issue(3'd0, 1'b0, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0055); complete(0);
    issue(3'd0, 1'b0, 3'd6, 3'd2, 3'd0, 1'b1, 16'h0100); complete(0);
    apply_reset();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 1);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); #1;
      check("rst_dbg", dbg_data, 16'h0000);
    end

    issue(3'd3, 1'b0, 3'd4, 3'd0, 3'd0, 1'b1, 16'hA5A5);
    complete(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
